chroma_blob_tracker: RTL and testbench
======================================

Name: chroma_blob_tracker

Overview:
Consumes the per-pixel chroma-key match flag and the aligned VGA pixel coordinates. Accumulates per-frame statistics of matched pixels: count, coordinate sums and bounding box. At each frame end it snapshots the statistics and runs a sequential restoring divider to produce the object centroid. Sits directly downstream of the chroma-key stage and feeds the overlay/compositing logic, which uses the centroid and bounding box.

Parameters:
H_ACTIVE, 1024, active pixels per line; hcount at or above this is ignored
V_ACTIVE, 768, active lines per frame; vcount at or above this is ignored
MIN_PIXELS, 64, minimum matched-pixel count for a valid object

Ports:
clk  in  1  pixel-domain clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  VGA vertical sync; its falling edge marks frame end
blank  in  1  1 = outside active video; pixel ignored
hcount  in  11  pixel x, aligned with chroma_key_match
vcount  in  10  pixel y, aligned with chroma_key_match
chroma_key_match  in  1  1 = pixel matched the key
centroid_x  out  11  floor(sum_x / count) of the last completed frame
centroid_y  out  10  floor(sum_y / count)
bbox_x_min, bbox_x_max  out  11 each  bounding box x
bbox_y_min, bbox_y_max  out  10 each  bounding box y
pixel_count  out  20  matched pixels in the last completed frame
object_found  out  1  pixel_count >= MIN_PIXELS
result_valid  out  1  one-cycle pulse when outputs update
busy  out  1  divider running
overrun  out  1  one-cycle pulse when a frame end is dropped

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; accumulators cleared; min trackers = (H_ACTIVE-1, V_ACTIVE-1); max trackers = 0; vsync_q = 1.
- Qualifying pixel: !blank && chroma_key_match && hcount < H_ACTIVE && vcount < V_ACTIVE.
- On a qualifying pixel: cnt += 1 (20 b); sx += hcount (30 b); sy += vcount (30 b); update min/max. Accumulation runs in every state.
- Frame end E is the clock edge where vsync_q = 1 and vsync = 0. vsync_q is a registered copy of vsync.
- At edge E (state IDLE):
  - Snapshot cnt, sx, sy and the min/max values into working registers.
  - Clear the accumulators and the min/max trackers. A qualifying pixel in that same cycle seeds the new frame.
  - If snapshot cnt >= MIN_PIXELS: go to DIV_X. Otherwise go to FINISH.
- At edge E while not IDLE:
  - Snapshot is discarded; accumulators are still cleared.
  - overrun pulses for 1 cycle.
  - The division in progress continues unaffected.
- DIV_X: 30-iteration restoring division sx / cnt, one quotient bit per edge, MSB first. Then go to DIV_Y.
- DIV_Y: same for sy / cnt. Then go to FINISH.
- FINISH: on the next edge, register all outputs, pulse result_valid, return to IDLE.
  - Below-threshold frame: object_found = 0; centroid and bbox outputs = 0; pixel_count = true count.
- busy = 1 in DIV_X, DIV_Y and FINISH.
- Latency: result_valid is high in the cycle after edge E+61 for a valid object, and after edge E+1 otherwise.
- Division widths: quotient truncated to 11 b (x) and 10 b (y). The quotient cannot exceed H_ACTIVE-1 or V_ACTIVE-1 by construction.
- Outputs hold their value between result_valid pulses.
- cnt saturates at 2^20-1; sx and sy do not overflow given the parameter bounds.
- Reset mid-division: returns to IDLE immediately; no result_valid is issued.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; busy = 0.
- Rectangle: match over x 100..109, y 50..59, then vsync falls -> after 61 edges result_valid = 1 for 1 cycle; pixel_count = 100; centroid = (104, 54); bbox = (100, 109, 50, 59); object_found = 1.
- Below threshold: 63 matched pixels at (500, 300) -> result_valid 1 edge after E; pixel_count = 63; object_found = 0; centroid and bbox = 0.
- Masking: match = 1 with blank = 1, or hcount = 1024, for all pixels, plus 64 legal pixels at (0, 0) -> pixel_count = 64; centroid = (0, 0); bbox all 0.
- Overrun: second vsync falling edge 20 cycles after the first -> overrun pulses; first result still valid at E+61; next frame's accumulation starts from zero.
- Reset mid-division: assert rst 15 cycles into DIV_X -> no result_valid; outputs 0; the next full frame produces a correct result.

Source files
------------

// File: rtl/chroma_blob_tracker.sv
// Per-frame statistics of chroma-key matched pixels (count, coordinate sums, bounding box)
// with a sequential restoring divider that turns the sums into a centroid at each frame end.
module chroma_blob_tracker #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        blank,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        chroma_key_match,
    output logic [10:0] centroid_x,
    output logic [9:0]  centroid_y,
    output logic [10:0] bbox_x_min,
    output logic [10:0] bbox_x_max,
    output logic [9:0]  bbox_y_min,
    output logic [9:0]  bbox_y_max,
    output logic [19:0] pixel_count,
    output logic        object_found,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);

    // state  | meaning
    // IDLE   | accumulating, waiting for frame end
    // DIV_X  | dividing sum_x by count, one quotient bit per cycle
    // DIV_Y  | dividing sum_y by count
    // FINISH | publish snapshot and quotients
    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, FINISH} state_t;

    localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
    localparam logic [10:0] X_MIN_INIT = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_MIN_INIT = 10'(V_ACTIVE - 1);
    localparam logic [19:0] MIN_CNT    = 20'(MIN_PIXELS);
    localparam logic [4:0]  ITER_LAST  = 5'd29;

    state_t state, state_nxt;

    logic        vsync_q;
    logic        frame_end;
    logic        pix_ok;

    logic [19:0] cnt;
    logic [29:0] sx, sy;
    logic [10:0] x_min, x_max;
    logic [9:0]  y_min, y_max;

    logic [19:0] w_cnt;
    logic [29:0] w_sy;
    logic [10:0] w_x_min, w_x_max;
    logic [9:0]  w_y_min, w_y_max;
    logic [29:0] div_q;
    logic [19:0] rem;
    logic [4:0]  iter;
    logic [10:0] q_x;
    logic [9:0]  q_y;

    logic [20:0] trial;
    logic        fits;
    logic [19:0] rem_nxt;
    logic [29:0] quo_nxt;
    logic        last_iter;
    logic        w_found;

    logic        snap_load;
    logic        div_step;
    logic        publish;

    assign frame_end = vsync_q & ~vsync;
    assign pix_ok    = ~blank & chroma_key_match & (hcount < H_LIM) & (vcount < V_LIM);
    assign last_iter = (iter == 5'd0);
    assign w_found   = (w_cnt >= MIN_CNT);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial   = {rem, div_q[29]};
    assign fits    = (trial >= {1'b0, w_cnt});
    assign rem_nxt = fits ? (trial[19:0] - w_cnt) : trial[19:0];
    assign quo_nxt = {div_q[28:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    state_nxt = (cnt >= MIN_CNT) ? DIV_X : FINISH;
                end
            end
            DIV_X:   if (last_iter) state_nxt = DIV_Y;
            DIV_Y:   if (last_iter) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        snap_load = (state == IDLE) && frame_end;
        div_step  = (state == DIV_X) || (state == DIV_Y);
        publish   = (state == FINISH);
    end

    // Accumulators run in every state; a frame end restarts them, seeded by the current pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b1;
            cnt     <= '0;
            sx      <= '0;
            sy      <= '0;
            x_min   <= X_MIN_INIT;
            x_max   <= '0;
            y_min   <= Y_MIN_INIT;
            y_max   <= '0;
        end else begin
            vsync_q <= vsync;
            if (frame_end) begin
                cnt   <= pix_ok ? 20'd1 : 20'd0;
                sx    <= pix_ok ? 30'(hcount) : 30'd0;
                sy    <= pix_ok ? 30'(vcount) : 30'd0;
                x_min <= pix_ok ? hcount : X_MIN_INIT;
                x_max <= pix_ok ? hcount : 11'd0;
                y_min <= pix_ok ? vcount : Y_MIN_INIT;
                y_max <= pix_ok ? vcount : 10'd0;
            end else if (pix_ok) begin
                if (cnt != '1) cnt <= cnt + 20'd1;
                sx <= sx + 30'(hcount);
                sy <= sy + 30'(vcount);
                if (hcount < x_min) x_min <= hcount;
                if (hcount > x_max) x_max <= hcount;
                if (vcount < y_min) y_min <= vcount;
                if (vcount > y_max) y_max <= vcount;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt   <= '0;
            w_sy    <= '0;
            w_x_min <= '0;
            w_x_max <= '0;
            w_y_min <= '0;
            w_y_max <= '0;
            div_q   <= '0;
            rem     <= '0;
            iter    <= '0;
            q_x     <= '0;
            q_y     <= '0;
        end else if (snap_load) begin
            w_cnt   <= cnt;
            w_sy    <= sy;
            w_x_min <= x_min;
            w_x_max <= x_max;
            w_y_min <= y_min;
            w_y_max <= y_max;
            div_q   <= sx;
            rem     <= '0;
            iter    <= ITER_LAST;
        end else if (div_step) begin
            div_q <= quo_nxt;
            rem   <= rem_nxt;
            iter  <= iter - 5'd1;
            if (last_iter) begin
                if (state == DIV_X) begin
                    q_x   <= quo_nxt[10:0];
                    div_q <= w_sy;
                    rem   <= '0;
                    iter  <= ITER_LAST;
                end else begin
                    q_y <= quo_nxt[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            centroid_x   <= '0;
            centroid_y   <= '0;
            bbox_x_min   <= '0;
            bbox_x_max   <= '0;
            bbox_y_min   <= '0;
            bbox_y_max   <= '0;
            pixel_count  <= '0;
            object_found <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= publish;
            overrun      <= frame_end && (state != IDLE);
            if (publish) begin
                pixel_count  <= w_cnt;
                object_found <= w_found;
                centroid_x   <= w_found ? q_x : 11'd0;
                centroid_y   <= w_found ? q_y : 10'd0;
                bbox_x_min   <= w_found ? w_x_min : 11'd0;
                bbox_x_max   <= w_found ? w_x_max : 11'd0;
                bbox_y_min   <= w_found ? w_y_min : 10'd0;
                bbox_y_max   <= w_found ? w_y_max : 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_chroma_blob_tracker.sv
// Directed bench for chroma_blob_tracker: rectangle, threshold, masking, overrun and reset cases.
module tb_chroma_blob_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b1;
    logic        blank = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        chroma_key_match = 1'b0;
    logic [10:0] centroid_x, bbox_x_min, bbox_x_max;
    logic [9:0]  centroid_y, bbox_y_min, bbox_y_max;
    logic [19:0] pixel_count;
    logic        object_found, result_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    chroma_blob_tracker dut (
        .clk(clk), .rst(rst), .vsync(vsync), .blank(blank),
        .hcount(hcount), .vcount(vcount), .chroma_key_match(chroma_key_match),
        .centroid_x(centroid_x), .centroid_y(centroid_y),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
        .pixel_count(pixel_count), .object_found(object_found),
        .result_valid(result_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y);
        blank = 1'b0;
        chroma_key_match = 1'b1;
        hcount = 11'(x);
        vcount = 10'(y);
        tick();
        blank = 1'b1;
        chroma_key_match = 1'b0;
    endtask

    task automatic end_frame();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic rectangle();
        for (int y = 50; y <= 59; y++)
            for (int x = 100; x <= 109; x++)
                pix(x, y);
    endtask

    task automatic check_result(input string tag, input int cnt, input int cx, input int cy,
                                input int xmn, input int xmx, input int ymn, input int ymx,
                                input int found);
        check({tag, ".valid"}, 32'(result_valid), 32'd1);
        check({tag, ".count"}, 32'(pixel_count), 32'(cnt));
        check({tag, ".cx"},    32'(centroid_x), 32'(cx));
        check({tag, ".cy"},    32'(centroid_y), 32'(cy));
        check({tag, ".xmin"},  32'(bbox_x_min), 32'(xmn));
        check({tag, ".xmax"},  32'(bbox_x_max), 32'(xmx));
        check({tag, ".ymin"},  32'(bbox_y_min), 32'(ymn));
        check({tag, ".ymax"},  32'(bbox_y_max), 32'(ymx));
        check({tag, ".found"}, 32'(object_found), 32'(found));
    endtask

    initial begin
        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("rst.valid", 32'(result_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.count", 32'(pixel_count), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.found", 32'(object_found), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 10x10 rectangle: x 100..109, y 50..59
        rectangle();
        end_frame();
        check("rect.busy", 32'(busy), 32'd1);
        check("rect.early_valid", 32'(result_valid), 32'd0);
        wait_valid(n);
        check("rect.latency", 32'(n), 32'd61);
        check_result("rect", 100, 104, 54, 100, 109, 50, 59, 1);
        check("rect.busy_done", 32'(busy), 32'd0);
        tick();
        check("rect.pulse", 32'(result_valid), 32'd0);
        check("rect.hold", 32'(pixel_count), 32'd100);

        // 63 pixels: one below the threshold
        repeat (63) pix(500, 300);
        end_frame();
        wait_valid(n);
        check("small.latency", 32'(n), 32'd1);
        check_result("small", 63, 0, 0, 0, 0, 0, 0, 0);

        // Masked matches (blank, out-of-range x and y) plus 64 legal pixels at the origin
        chroma_key_match = 1'b1;
        blank = 1'b1; hcount = 11'd10; vcount = 10'd10;
        repeat (20) tick();
        blank = 1'b0; hcount = 11'd1024; vcount = 10'd5;
        repeat (20) tick();
        hcount = 11'd2047;
        repeat (5) tick();
        hcount = 11'd7; vcount = 10'd768;
        repeat (20) tick();
        blank = 1'b1; chroma_key_match = 1'b0;
        repeat (64) pix(0, 0);
        end_frame();
        wait_valid(n);
        check("mask.latency", 32'(n), 32'd61);
        check_result("mask", 64, 0, 0, 0, 0, 0, 0, 1);

        // Overrun: second frame end 20 cycles after the first
        for (int y = 10; y <= 17; y++)
            for (int x = 200; x <= 207; x++)
                pix(x, y);
        end_frame();
        check("ovr.first", 32'(overrun), 32'd0);
        repeat (5) pix(900, 700);
        repeat (14) tick();
        end_frame();
        check("ovr.pulse", 32'(overrun), 32'd1);
        check("ovr.busy", 32'(busy), 32'd1);
        pix(600, 200);
        check("ovr.pulse_end", 32'(overrun), 32'd0);
        repeat (9) pix(600, 200);
        wait_valid(n);
        check("ovr.latency", 32'(n + 30), 32'd61);
        check_result("ovr", 64, 203, 13, 200, 207, 10, 17, 1);
        repeat (54) pix(600, 200);
        end_frame();
        wait_valid(n);
        check("next.latency", 32'(n), 32'd61);
        check_result("next", 64, 600, 200, 600, 600, 200, 200, 1);

        // Reset 15 cycles into DIV_X
        rectangle();
        end_frame();
        repeat (15) tick();
        #3 rst = 1'b1;
        #1;
        check("mid.valid", 32'(result_valid), 32'd0);
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.count", 32'(pixel_count), 32'd0);
        check("mid.cx", 32'(centroid_x), 32'd0);
        check("mid.xmax", 32'(bbox_x_max), 32'd0);
        check("mid.found", 32'(object_found), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (result_valid) seen = 1'b1;
        end
        check("mid.no_valid", 32'(seen), 32'd0);
        rectangle();
        end_frame();
        wait_valid(n);
        check("after.latency", 32'(n), 32'd61);
        check_result("after", 100, 104, 54, 100, 109, 50, 59, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
